// File: rtl/mem_stage.sv
// MEM pipeline stage: branch resolve, word-addressed data memory, MEM/WB buffer.
// Optional MEM_ALIGN_CHECK_EN adds a registered misaligned flag and squashes such accesses.
`ifndef WORD
`define WORD [31:0]
`endif

module mem_stage #(
    parameter int DEPTH     = 256,
    parameter int ADDR_BITS = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic `WORD Branch_Target,
    input  logic `WORD Result,
    input  logic `WORD MemWriteData,
    input  logic [4:0] RegDstAddress,
    input  logic       zero,
    input  logic       Branch,
    input  logic       MemRead,
    input  logic       MemWrite,
    input  logic       RegWrite_in,
    input  logic       MemtoReg_in,
    output logic       PCSrc,
    output logic `WORD Branch_Target_out,
    output logic `WORD ReadData,
    output logic `WORD ALUResult,
    output logic [4:0] RegDstAddress_out,
    output logic       RegWrite_out,
`ifdef MEM_ALIGN_CHECK_EN
    output logic       misaligned,
`endif
    output logic       MemtoReg_out
);

    logic `WORD           mem_q [DEPTH];
    logic [ADDR_BITS-1:0] idx;
    logic                 mis_d;

    logic `WORD read_data_d, read_data_q;
    logic `WORD alu_d, alu_q;
    logic [4:0] rd_d, rd_q;
    logic       regwrite_d, regwrite_q;
    logic       memtoreg_d, memtoreg_q;

    assign PCSrc             = Branch & zero;
    assign Branch_Target_out = Branch_Target;

    // Upper address bits are dropped, so accesses wrap around the array.
    assign idx = Result[ADDR_BITS+1:2];

`ifdef MEM_ALIGN_CHECK_EN
    assign mis_d = (MemRead | MemWrite) & (Result[1:0] != 2'b00);
`else
    assign mis_d = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset && MemWrite && !mis_d) begin
            mem_q[idx] <= MemWriteData;
        end
    end

    always_comb begin
        read_data_d = '0;
        alu_d       = Result;
        rd_d        = RegDstAddress;
        regwrite_d  = RegWrite_in & ~mis_d;
        memtoreg_d  = MemtoReg_in;
        // Read-first: mem_q still holds the pre-write word at this edge.
        if (MemRead && !mis_d) begin
            read_data_d = mem_q[idx];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            read_data_q <= '0;
            alu_q       <= '0;
            rd_q        <= '0;
            regwrite_q  <= 1'b0;
            memtoreg_q  <= 1'b0;
        end else begin
            read_data_q <= read_data_d;
            alu_q       <= alu_d;
            rd_q        <= rd_d;
            regwrite_q  <= regwrite_d;
            memtoreg_q  <= memtoreg_d;
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    logic mis_q;
    always_ff @(posedge clk) begin
        if (!reset) begin
            mis_q <= 1'b0;
        end else begin
            mis_q <= mis_d;
        end
    end
    assign misaligned = mis_q;
`endif

    assign ReadData          = read_data_q;
    assign ALUResult         = alu_q;
    assign RegDstAddress_out = rd_q;
    assign RegWrite_out      = regwrite_q;
    assign MemtoReg_out      = memtoreg_q;

endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage against a behavioural memory model.
module tb_mem_stage;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] Branch_Target = '0, Result = '0, MemWriteData = '0;
    logic [4:0]  RegDstAddress = '0;
    logic        zero = 1'b0, Branch = 1'b0, MemRead = 1'b0, MemWrite = 1'b0;
    logic        RegWrite_in = 1'b0, MemtoReg_in = 1'b0;
    logic        PCSrc;
    logic [31:0] Branch_Target_out, ReadData, ALUResult;
    logic [4:0]  RegDstAddress_out;
    logic        RegWrite_out, MemtoReg_out;
`ifdef MEM_ALIGN_CHECK_EN
    logic        misaligned;
`endif

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] model_mem [DEPTH];

    always #5 clk = ~clk;

    mem_stage #(.DEPTH(DEPTH), .ADDR_BITS(8)) dut (
        .clk(clk), .reset(reset),
        .Branch_Target(Branch_Target), .Result(Result), .MemWriteData(MemWriteData),
        .RegDstAddress(RegDstAddress), .zero(zero), .Branch(Branch),
        .MemRead(MemRead), .MemWrite(MemWrite),
        .RegWrite_in(RegWrite_in), .MemtoReg_in(MemtoReg_in),
        .PCSrc(PCSrc), .Branch_Target_out(Branch_Target_out),
        .ReadData(ReadData), .ALUResult(ALUResult),
        .RegDstAddress_out(RegDstAddress_out), .RegWrite_out(RegWrite_out),
`ifdef MEM_ALIGN_CHECK_EN
        .misaligned(misaligned),
`endif
        .MemtoReg_out(MemtoReg_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Applies current inputs for one cycle and checks against the model.
    task automatic do_cycle();
        int          widx;
        bit          bad;
        logic [31:0] e_rd, e_alu;
        logic [4:0]  e_rdst;
        logic        e_rw, e_m2r;
        #1;
        check("pcsrc", {31'b0, PCSrc}, {31'b0, Branch && zero});
        check("br_target", Branch_Target_out, Branch_Target);
        @(posedge clk);
        widx = int'((Result / 4) % DEPTH);
        bad = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        bad = (MemRead || MemWrite) && (Result % 4 != 0);
`endif
        if (!reset) begin
            e_rd = 0; e_alu = 0; e_rdst = 0; e_rw = 0; e_m2r = 0; bad = 1'b0;
        end else begin
            e_rd   = (MemRead && !bad) ? model_mem[widx] : 32'h0;
            e_alu  = Result;
            e_rdst = RegDstAddress;
            e_rw   = RegWrite_in && !bad;
            e_m2r  = MemtoReg_in;
            if (MemWrite && !bad) model_mem[widx] = MemWriteData;
        end
        #2;
        check("read_data", ReadData, e_rd);
        check("alu_result", ALUResult, e_alu);
        check("rd_addr", {27'b0, RegDstAddress_out}, {27'b0, e_rdst});
        check("reg_write", {31'b0, RegWrite_out}, {31'b0, e_rw});
        check("mem_to_reg", {31'b0, MemtoReg_out}, {31'b0, e_m2r});
`ifdef MEM_ALIGN_CHECK_EN
        check("misaligned", {31'b0, misaligned}, {31'b0, bad});
`endif
    endtask

    task automatic op(input logic rst, input logic [31:0] res, input logic [31:0] wd,
                      input logic mr, input logic mw, input logic m2r);
        reset = rst; Result = res; MemWriteData = wd;
        MemRead = mr; MemWrite = mw; MemtoReg_in = m2r;
        RegWrite_in = mr; RegDstAddress = 5'($urandom_range(0, 31));
        Branch = 1'b0; zero = 1'b0;
        Branch_Target = $urandom;
        do_cycle();
    endtask

    initial begin
        // Reset state
        op(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        op(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

        // Fill memory so every later load has a known value
        for (int i = 0; i < DEPTH; i++) op(1'b1, i * 4, $urandom, 1'b0, 1'b1, 1'b0);

        // Store then load
        op(1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0);
        op(1'b1, 32'h10, 32'h0, 1'b1, 1'b0, 1'b1);
        check("st_ld_direct", ReadData, 32'hDEADBEEF);

        // Read-first collision
        op(1'b1, 32'h10, 32'h11, 1'b0, 1'b1, 1'b0);
        op(1'b1, 32'h10, 32'h22, 1'b1, 1'b1, 1'b0);
        check("collision_old", ReadData, 32'h11);
        op(1'b1, 32'h10, 32'h0, 1'b1, 1'b0, 1'b0);
        check("collision_new", ReadData, 32'h22);

        // Branch resolve
        reset = 1'b1; MemRead = 0; MemWrite = 0;
        Branch = 1'b1; zero = 1'b1; Branch_Target = 32'h40;
        #1;
        check("pcsrc_taken", {31'b0, PCSrc}, 32'h1);
        check("bt_40", Branch_Target_out, 32'h40);
        zero = 1'b0;
        #1;
        check("pcsrc_not_taken", {31'b0, PCSrc}, 32'h0);
        do_cycle();

        // Reset mid-operation and store under reset
        op(1'b1, 32'h20, 32'h0, 1'b1, 1'b0, 1'b1);
        op(1'b0, 32'h20, 32'hCAFEF00D, 1'b1, 1'b1, 1'b1);
        check("rst_flush", ReadData, 32'h0);
        op(1'b1, 32'h20, 32'h0, 1'b1, 1'b0, 1'b0);
        check("rst_no_store", ReadData, model_mem[8]);

        // Wrap-around
        op(1'b1, 32'h400, 32'h5A5A5A5A, 1'b0, 1'b1, 1'b0);
        op(1'b1, 32'h000, 32'h0, 1'b1, 1'b0, 1'b0);
        check("wrap", ReadData, 32'h5A5A5A5A);

        // Misaligned store then aligned load of the containing word
        op(1'b1, 32'h10, 32'h33, 1'b0, 1'b1, 1'b0);
        op(1'b1, 32'h12, 32'h77, 1'b0, 1'b1, 1'b0);
        op(1'b1, 32'h10, 32'h0, 1'b1, 1'b0, 1'b0);
`ifdef MEM_ALIGN_CHECK_EN
        check("misaligned_kept", ReadData, 32'h33);
`else
        check("misaligned_lands", ReadData, 32'h77);
`endif

        // Random traffic
        for (int n = 0; n < 2000; n++) begin
            reset         = ($urandom_range(0, 39) != 0);
            Result        = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 31) << 2)
                          | (($urandom_range(0, 9) == 0) ? $urandom_range(1, 3) : 0);
            MemWriteData  = $urandom;
            MemRead       = 1'($urandom_range(0, 1));
            MemWrite      = 1'($urandom_range(0, 1));
            RegWrite_in   = 1'($urandom_range(0, 1));
            MemtoReg_in   = 1'($urandom_range(0, 1));
            RegDstAddress = 5'($urandom_range(0, 31));
            Branch        = 1'($urandom_range(0, 1));
            zero          = 1'($urandom_range(0, 1));
            Branch_Target = $urandom;
            do_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
